dma_width_bridge: RTL

DMA_WIDTH_BRIDGE -- requirements
Module: dma_width_bridge

---
 rtl/dma_width_bridge.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_width_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dma_width_bridge
// Purpose  : Bidirectional width-converting DMA bridge between a CPU_W-bit
//            CPU port and a MEM_W-bit (CPU_W/RATIO) memory port, buffered by
//            a DEPTH-entry FIFO of CPU words.
//              mode 1 (cpu->mem): CPU words are pushed whole and leave as
//                                 RATIO slices, least-significant first.
//              mode 0 (mem->cpu): MEM slices are packed LSB-first into a CPU
//                                 word, which is pushed on the last slice.
//            A transfer moves xfer_len CPU words and ends with a one-cycle
//            done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, resetn        : clock; synchronous active-low reset
//   mode, start,
//   xfer_len           : transfer control, sampled only in IDLE with start
//   busy, done         : transfer in progress / one-cycle completion pulse
//   cpu_to_dma_valid,
//   cpu_data_out,
//   cpu_to_dma_enable  : CPU source channel (mode 1)
//   dma_to_cpu_valid,
//   cpu_data_in,
//   dma_to_cpu_enable  : CPU sink channel (mode 0)
//   mem_to_dma_valid,
//   mem_data_out,
//   mem_to_dma_enable  : MEM source channel (mode 0)
//   dma_to_mem_valid,
//   mem_data_in,
//   dma_to_mem_enable  : MEM sink channel (mode 1)
// ============================================================================
module dma_width_bridge #(
  parameter int CPU_W = 8,
  parameter int RATIO = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mode,
  input  logic                   start,
  input  logic [CNT_W-1:0]       xfer_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   cpu_to_dma_valid,
  input  logic [CPU_W-1:0]       cpu_data_out,
  output logic                   cpu_to_dma_enable,
  output logic                   dma_to_cpu_valid,
  output logic [CPU_W-1:0]       cpu_data_in,
  input  logic                   dma_to_cpu_enable,
  input  logic                   mem_to_dma_valid,
  input  logic [CPU_W/RATIO-1:0] mem_data_out,
  output logic                   mem_to_dma_enable,
  output logic                   dma_to_mem_valid,
  output logic [CPU_W/RATIO-1:0] mem_data_in,
  input  logic                   dma_to_mem_enable
);

  localparam int MEM_W = CPU_W / RATIO;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [PTR_W:0]   c_DEPTH    = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Latched transfer parameters
  logic               r_mode;
  logic [CNT_W-1:0]   r_len;

  // Word counters: source counts words entering the FIFO, sink counts words
  // fully delivered out of it.
  logic [CNT_W-1:0]   r_src_cnt;
  logic [CNT_W-1:0]   r_sink_cnt;

  // FIFO of CPU words
  logic [CPU_W-1:0]   r_fifo [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  // Slice bookkeeping: r_in_idx selects the slice being assembled (mode 0),
  // r_out_idx selects the head slice being presented (mode 1).
  logic [IDX_W-1:0]   r_in_idx;
  logic [IDX_W-1:0]   r_out_idx;
  logic [CPU_W-1:0]   r_asm;

  logic               w_run;
  logic               w_full;
  logic               w_empty;
  logic               w_src_en;
  logic               w_out_valid;
  logic [CPU_W-1:0]   w_head;
  logic [MEM_W-1:0]   w_head_slice;
  logic [CPU_W-1:0]   w_asm_word;
  logic [CPU_W-1:0]   w_push_data;
  logic               w_cpu_in_beat;
  logic               w_mem_in_beat;
  logic               w_cpu_out_beat;
  logic               w_mem_out_beat;
  logic               w_push;
  logic               w_pop;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_src_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (xfer_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        // Source throttles on a full FIFO and stops once every word of the
        // transfer has been accepted.
        w_src_en = !w_full && (r_src_cnt < r_len);
        if (r_sink_cnt == r_len) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Channel handshakes. Every output below is a function of registers only.
  // --------------------------------------------------------------------------
  assign w_run   = (r_state == S_RUN);
  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  assign w_out_valid = w_run && !w_empty;

  assign cpu_to_dma_enable = w_src_en &  r_mode;
  assign mem_to_dma_enable = w_src_en & ~r_mode;
  assign dma_to_mem_valid  = w_out_valid &  r_mode;
  assign dma_to_cpu_valid  = w_out_valid & ~r_mode;

  // Data is forced to zero whenever the matching valid is low so that the
  // idle/reset state presents all-zero outputs regardless of FIFO contents.
  assign cpu_data_in = dma_to_cpu_valid ? w_head       : '0;
  assign mem_data_in = dma_to_mem_valid ? w_head_slice : '0;

  assign w_cpu_in_beat  = cpu_to_dma_valid & cpu_to_dma_enable;
  assign w_mem_in_beat  = mem_to_dma_valid & mem_to_dma_enable;
  assign w_cpu_out_beat = dma_to_cpu_valid & dma_to_cpu_enable;
  assign w_mem_out_beat = dma_to_mem_valid & dma_to_mem_enable;

  // A word enters the FIFO on a CPU beat, or on the final MEM slice.
  assign w_push = w_cpu_in_beat | (w_mem_in_beat & (r_in_idx == c_LAST_IDX));
  // A word leaves the FIFO on a CPU beat, or once its final slice is taken.
  assign w_pop  = w_cpu_out_beat | (w_mem_out_beat & (r_out_idx == c_LAST_IDX));

  assign w_push_data = r_mode ? cpu_data_out : w_asm_word;

  // Head slice selected by the output slice index, slice 0 = LSBs.
  always_comb begin
    w_head_slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_out_idx == IDX_W'(i)) begin
        w_head_slice = w_head[i*MEM_W +: MEM_W];
      end
    end
  end

  // Assembly word with the incoming slice merged at the current index. On the
  // final slice this is the complete word that gets pushed, so the slice does
  // not have to be registered first.
  always_comb begin
    w_asm_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_in_idx == IDX_W'(i)) begin
        w_asm_word[i*MEM_W +: MEM_W] = mem_data_out;
      end else begin
        w_asm_word[i*MEM_W +: MEM_W] = r_asm[i*MEM_W +: MEM_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mode     <= 1'b0;
      r_len      <= '0;
      r_src_cnt  <= '0;
      r_sink_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_idx   <= '0;
      r_out_idx  <= '0;
      r_asm      <= '0;
    end else if (r_state == S_IDLE) begin
      // Parameters are captured only here, so changes on mode/xfer_len
      // during a transfer have no effect. Everything else is re-armed.
      if (start) begin
        r_mode <= mode;
        r_len  <= xfer_len;
      end
      r_src_cnt  <= '0;
      r_sink_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_idx   <= '0;
      r_out_idx  <= '0;
      r_asm      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        r_src_cnt <= r_src_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_sink_cnt <= r_sink_cnt + CNT_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

      if (w_mem_in_beat) begin
        r_asm    <= w_asm_word;
        r_in_idx <= (r_in_idx == c_LAST_IDX) ? '0 : r_in_idx + IDX_W'(1);
      end
      if (w_mem_out_beat) begin
        r_out_idx <= (r_out_idx == c_LAST_IDX) ? '0 : r_out_idx + IDX_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. Contents need no reset: reads are masked by valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_data;
    end
  end

endmodule
`default_nettype wire
